// File: rtl/mem_if_pkg.sv
// Shared definitions for the paired-word RAM handshake, used by the initiator and the RAM.
package mem_if_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int WORD_W_DEF = 10;
    localparam int BUS_W_DEF  = 2 * WORD_W_DEF;

    localparam logic [BUS_W_DEF-1:0] BUS_RELEASE = {BUS_W_DEF{1'bz}};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_HIGH = 2'd2,
        DONE      = 2'd3
    } mem_state_e;

    // Odd word addresses live in the upper half of the paired-word bus.
    function automatic logic [WORD_W_DEF-1:0] half_sel(
        input logic [BUS_W_DEF-1:0] bus,
        input logic                 odd
    );
        return odd ? bus[BUS_W_DEF-1:WORD_W_DEF] : bus[WORD_W_DEF-1:0];
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Transaction watchdog: cleared at request accept, counts while enabled, flags TIMEOUT-1.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired = (cnt_q == CNT_LAST);

    // Saturates at the terminal count so a late enable cannot wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_master.sv
// Initiator for the mem_req/mem_ready handshake to the paired-word RAM over a shared tri-state bus.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   IDLE      | cpu_ready high, waiting for cpu_req
//   REQ       | mem_req high, waiting for RAM to drop mem_ready
//   WAIT_HIGH | mem_req low, waiting for mem_ready to return (read data valid)
//   DONE      | one-cycle cpu_done (and cpu_err on timeout), bus released
module mem_master
    import mem_if_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int WORD_W  = WORD_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [WORD_W-1:0]   cpu_wdata,
    output logic                cpu_ready,
    output logic [WORD_W-1:0]   cpu_rdata,
    output logic                cpu_done,
    output logic                cpu_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    inout  wire  [2*WORD_W-1:0] data,
    input  logic                mem_ready
);

    mem_state_e         state_q,     state_d;
    logic               mem_req_q,   mem_req_d;
    logic               mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q,  mem_addr_d;
    logic [WORD_W-1:0]  wdata_q,     wdata_d;
    logic               drive_q,     drive_d;
    logic               cpu_ready_q, cpu_ready_d;
    logic [WORD_W-1:0]  cpu_rdata_q, cpu_rdata_d;
    logic               cpu_done_q,  cpu_done_d;
    logic               cpu_err_q,   cpu_err_d;

    logic ctr_clr;
    logic ctr_en;
    logic ctr_expired;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (ctr_clr),
        .en      (ctr_en),
        .expired (ctr_expired)
    );

    // Both halves carry the write word so the RAM can pick either by addr[0].
    assign data = drive_q ? {wdata_q, wdata_q} : BUS_RELEASE;

    assign cpu_ready = cpu_ready_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_done  = cpu_done_q;
    assign cpu_err   = cpu_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        wdata_d     = wdata_q;
        drive_d     = drive_q;
        cpu_ready_d = cpu_ready_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_done_d  = 1'b0;
        cpu_err_d   = 1'b0;
        ctr_clr     = 1'b0;
        ctr_en      = 1'b0;

        unique case (state_q)
            IDLE: begin
                cpu_ready_d = 1'b1;
                if (cpu_req) begin
                    mem_we_d    = cpu_we;
                    mem_addr_d  = cpu_addr;
                    wdata_d     = cpu_wdata;
                    drive_d     = cpu_we;
                    mem_req_d   = 1'b1;
                    cpu_ready_d = 1'b0;
                    ctr_clr     = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                // mem_ready high here is the RAM's idle level, not an acknowledge.
                ctr_en = 1'b1;
                if (ctr_expired) begin
                    state_d    = DONE;
                    mem_req_d  = 1'b0;
                    drive_d    = 1'b0;
                    mem_we_d   = 1'b0;
                    cpu_done_d = 1'b1;
                    cpu_err_d  = 1'b1;
                end else if (!mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                ctr_en = 1'b1;
                if (mem_ready || ctr_expired) begin
                    state_d    = DONE;
                    mem_req_d  = 1'b0;
                    drive_d    = 1'b0;
                    mem_we_d   = 1'b0;
                    cpu_done_d = 1'b1;
                    cpu_err_d  = !mem_ready;
                    if (mem_ready && !mem_we_q) begin
                        cpu_rdata_d = half_sel(data, mem_addr_q[0]);
                    end
                end
            end
            DONE: begin
                state_d     = IDLE;
                cpu_ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            wdata_q     <= '0;
            drive_q     <= 1'b0;
            cpu_ready_q <= 1'b1;
            cpu_rdata_q <= '0;
            cpu_done_q  <= 1'b0;
            cpu_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            wdata_q     <= wdata_d;
            drive_q     <= drive_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_done_q  <= cpu_done_d;
            cpu_err_q   <= cpu_err_d;
        end
    end

endmodule

// File: tb/tb_mem_master.sv
// Scoreboard bench for mem_master against a 3-phase paired-word RAM model on a pulled-up bus.
module tb_mem_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [9:0]  cpu_addr = '0;
    logic [9:0]  cpu_wdata = '0;
    logic        cpu_ready;
    logic [9:0]  cpu_rdata;
    logic        cpu_done;
    logic        cpu_err;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic        mem_ready;
    wire  [19:0] data;

    localparam logic [19:0] BUS_IDLE = 20'hFFFFF;

    pullup (data);

    mem_master #(
        .ADDR_W  (10),
        .WORD_W  (10),
        .TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .cpu_done  (cpu_done),
        .cpu_err   (cpu_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .data      (data),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    // RAM model: ready drops the edge after mem_req is seen, returns two edges later with read data.
    logic [9:0]  ram [0:1023];
    logic [1:0]  ram_ph;
    logic        ram_rdy_q;
    logic        ram_drv;
    logic [9:0]  ram_a;
    logic        ram_we_l;
    logic        hold_ready = 1'b0;
    logic [19:0] ram_dval;

    assign mem_ready = hold_ready | ram_rdy_q;
    assign ram_dval  = {ram[{ram_a[9:1], 1'b1}], ram[{ram_a[9:1], 1'b0}]};
    assign data      = ram_drv ? ram_dval : 20'bz;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_ph    <= 2'd0;
            ram_rdy_q <= 1'b1;
            ram_drv   <= 1'b0;
            ram_a     <= '0;
            ram_we_l  <= 1'b0;
            for (int i = 0; i < 1024; i++) ram[i] <= '0;
            ram[10] <= 10'd5;
            ram[11] <= 10'd3;
            ram[50] <= 10'd9;
        end else begin
            ram_drv <= 1'b0;
            case (ram_ph)
                2'd0: if (mem_req && !hold_ready) begin
                    ram_rdy_q <= 1'b0;
                    ram_ph    <= 2'd1;
                    ram_a     <= mem_addr;
                    ram_we_l  <= mem_we;
                    if (mem_we) ram[mem_addr] <= mem_addr[0] ? data[19:10] : data[9:0];
                end
                2'd1: ram_ph <= 2'd2;
                default: begin
                    ram_ph    <= 2'd0;
                    ram_rdy_q <= 1'b1;
                    ram_drv   <= !ram_we_l;
                end
            endcase
        end
    end

    typedef struct packed {
        logic [9:0] rdata;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_e;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && cpu_done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", {31'd0, cpu_done}, 32'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check("sb_rdata", {22'd0, cpu_rdata}, {22'd0, exp_e.rdata});
                check("sb_err", {31'd0, cpu_err}, {31'd0, exp_e.err});
            end
        end
        if (rst_n && cpu_err && !cpu_done) check("err_without_done", {31'd0, cpu_err}, 32'd0);
    end

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 20 && !cpu_ready; i++) @(negedge clk);
        check({tag, "_ready"}, {31'd0, cpu_ready}, 32'd1);
    endtask

    // Latency counts negedges from issue; cpu_done is seen at the 5th for a normal transfer.
    task automatic do_txn(input logic we, input logic [9:0] addr, input logic [9:0] wd,
                          input logic [9:0] exp_rd, input logic exp_err, input int exp_lat,
                          input string tag);
        int lat     = 0;
        bit bus_ok  = 1'b1;
        bit addr_ok = 1'b1;
        wait_ready(tag);
        exp_q.push_back(exp_t'{rdata: exp_rd, err: exp_err});
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                cpu_req = 1'b0;
                check({tag, "_mem_req_high"}, {31'd0, mem_req}, 32'd1);
            end
            if (cpu_done) begin
                lat = c;
                break;
            end
            if (mem_addr !== addr || mem_we !== we) addr_ok = 1'b0;
            if (we) begin
                if (data !== {wd, wd}) bus_ok = 1'b0;
            end else if (data !== (ram_drv ? ram_dval : BUS_IDLE)) begin
                bus_ok = 1'b0;
            end
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_mem_req_low_done"}, {31'd0, mem_req}, 32'd0);
        check({tag, "_bus_released_done"}, {12'd0, data}, {12'd0, BUS_IDLE});
        check({tag, "_mem_we_cleared"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_addr_we_held"}, {31'd0, addr_ok}, 32'd1);
        check({tag, "_bus_drive"}, {31'd0, bus_ok}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc;
        int first_acc;
        int second_acc;
        logic prev_rdy;

        #1 rst_n = 1'b0;
        #3;
        check("rst_cpu_ready", {31'd0, cpu_ready}, 32'd1);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        check("rst_cpu_rdata", {22'd0, cpu_rdata}, 32'd0);
        check("rst_cpu_done", {31'd0, cpu_done}, 32'd0);
        check("rst_cpu_err", {31'd0, cpu_err}, 32'd0);
        check("rst_bus", {12'd0, data}, {12'd0, BUS_IDLE});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_txn(1'b0, 10'd10, 10'd0, 10'h005, 1'b0, 5, "rd10");
        do_txn(1'b0, 10'd11, 10'd0, 10'h003, 1'b0, 5, "rd11");
        do_txn(1'b1, 10'd51, 10'h02A, 10'h003, 1'b0, 5, "wr51");
        do_txn(1'b0, 10'd51, 10'd0, 10'h02A, 1'b0, 5, "rd51");
        do_txn(1'b0, 10'd50, 10'd0, 10'h009, 1'b0, 5, "rd50");

        // 16 cycles in REQ, then the DONE cycle; rdata keeps the previous read.
        hold_ready = 1'b1;
        do_txn(1'b0, 10'd11, 10'd0, 10'h009, 1'b1, 17, "tmo");
        hold_ready = 1'b0;

        wait_ready("rstmid");
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'd60; cpu_wdata = 10'h155;
        @(negedge clk);
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_bus_z", {12'd0, data}, {12'd0, BUS_IDLE});
        check("rstmid_mem_req", {31'd0, mem_req}, 32'd0);
        check("rstmid_mem_we", {31'd0, mem_we}, 32'd0);
        check("rstmid_cpu_ready", {31'd0, cpu_ready}, 32'd1);
        check("rstmid_rdata", {22'd0, cpu_rdata}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        do_txn(1'b0, 10'd10, 10'd0, 10'h005, 1'b0, 5, "rd10_post_rst");

        wait_ready("held");
        exp_q.push_back(exp_t'{rdata: 10'h003, err: 1'b0});
        exp_q.push_back(exp_t'{rdata: 10'h003, err: 1'b0});
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd11;
        prev_rdy = cpu_ready;
        n_acc = 0; first_acc = 0; second_acc = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (prev_rdy && !cpu_ready) begin
                n_acc++;
                if (n_acc == 1) first_acc = c;
                else if (n_acc == 2) second_acc = c;
            end
            prev_rdy = cpu_ready;
        end
        cpu_req = 1'b0;
        check("held_accept_count", n_acc, 2);
        check("held_accept_spacing", second_acc - first_acc, 6);

        wait_ready("pulse");
        exp_q.push_back(exp_t'{rdata: 10'h005, err: 1'b0});
        cpu_req = 1'b1; cpu_addr = 10'd10;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            cpu_req = (c == 2 || c == 4);
            cpu_addr = (c == 2 || c == 4) ? 10'd11 : 10'd10;
        end
        cpu_req = 1'b0;
        repeat (10) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
